// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers, pointer wrap function and read-mode encoding for sync_fifo.
package sync_fifo_pkg;

    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    function automatic int PTR_W(input int size);
        return $clog2(size);
    endfunction

    function automatic int LVL_W(input int size);
        return $clog2(size + 1);
    endfunction

    // Explicit modulo-size increment so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned size);
        return (ptr == size - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wrap_ctr.sv
// Modulo-SIZE pointer register; advances by one on inc and wraps SIZE-1 -> 0.
module fifo_wrap_ctr
    import sync_fifo_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      inc,
    output logic [PTR_W(SIZE)-1:0]    ptr
);

    localparam int PW = PTR_W(SIZE);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= PW'(next_ptr(32'(r_ptr), SIZE));
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with arbitrary depth, exact fill level, programmable thresholds,
// optional first-word-fall-through reads and registered overflow/underflow pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int BITS      = 32,
    parameter int SIZE      = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = SIZE - 2,
    parameter int AE_THRESH = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [BITS-1:0]           wr_data,
    output logic                      wr_full,
    output logic                      wr_almost_full,
    input  logic                      rd_en,
    output logic [BITS-1:0]           rd_data,
    output logic                      rd_empty,
    output logic                      rd_almost_empty,
    output logic [LVL_W(SIZE)-1:0]    level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = PTR_W(SIZE);
    localparam int LW = LVL_W(SIZE);

    if (SIZE < 2) begin : g_chk_size
        $error("sync_fifo: SIZE must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > SIZE) begin : g_chk_af
        $error("sync_fifo: AF_THRESH must be in 1..SIZE");
    end
    if (AE_THRESH < 0 || AE_THRESH >= SIZE) begin : g_chk_ae
        $error("sync_fifo: AE_THRESH must be in 0..SIZE-1");
    end
    if (FWFT != int'(RD_STD) && FWFT != int'(RD_FWFT)) begin : g_chk_fwft
        $error("sync_fifo: FWFT must be 0 or 1");
    end

    logic [BITS-1:0] r_mem [SIZE];
    logic [LW-1:0]   r_level;
    logic            r_overflow;
    logic            r_underflow;
    logic [PW-1:0]   w_wr_ptr;
    logic [PW-1:0]   w_rd_ptr;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // Accepts use the registered flags, so a full write or empty read is dropped
    // regardless of what the other side does in the same cycle.
    assign w_wr_acc = wr_en & ~wr_full;
    assign w_rd_acc = rd_en & ~rd_empty;

    fifo_wrap_ctr #(.SIZE(SIZE)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_acc),
        .ptr (w_wr_ptr)
    );

    fifo_wrap_ctr #(.SIZE(SIZE)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_acc),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc && !w_rd_acc) begin
                r_level <= r_level + LW'(1);
            end else if (!w_wr_acc && w_rd_acc) begin
                r_level <= r_level - LW'(1);
            end
            r_overflow  <= wr_en & wr_full;
            r_underflow <= rd_en & rd_empty;
        end
    end

    assign level           = r_level;
    assign wr_full         = (r_level == LW'(SIZE));
    assign rd_empty        = (r_level == '0);
    assign wr_almost_full  = (r_level >= LW'(AF_THRESH));
    assign rd_almost_empty = (r_level <= LW'(AE_THRESH));
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

    if (FWFT == int'(RD_FWFT)) begin : g_fwft
        assign rd_data = r_mem[w_rd_ptr];
    end else begin : g_std
        logic [BITS-1:0] r_rd_data;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_data <= '0;
            end else if (w_rd_acc) begin
                r_rd_data <= r_mem[w_rd_ptr];
            end
        end

        assign rd_data = r_rd_data;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: three instances (depth 5 standard, depth 16 thresholds,
// depth 5 FWFT) checked against a queue scoreboard and a reference occupancy count.
module tb_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instance A: BITS=8, SIZE=5, standard reads, default thresholds (AF=3, AE=1)
    logic       a_rst = 1'b1, a_wr = 1'b0, a_rd = 1'b0;
    logic [7:0] a_wd = 8'h00;
    logic       a_full, a_af, a_empty, a_ae, a_ov, a_un;
    logic [7:0] a_rdd;
    logic [2:0] a_lvl;
    int         a_m = 0;
    logic [7:0] a_q[$];
    logic [7:0] a_last = 8'h00;

    sync_fifo #(.BITS(8), .SIZE(5), .FWFT(0)) u_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr), .wr_data(a_wd), .wr_full(a_full),
        .wr_almost_full(a_af), .rd_en(a_rd), .rd_data(a_rdd), .rd_empty(a_empty),
        .rd_almost_empty(a_ae), .level(a_lvl), .overflow(a_ov), .underflow(a_un)
    );

    // Instance T: BITS=8, SIZE=16, AF_THRESH=12, AE_THRESH=3
    logic       t_rst = 1'b1, t_wr = 1'b0, t_rd = 1'b0;
    logic [7:0] t_wd = 8'h00;
    logic       t_full, t_af, t_empty, t_ae, t_ov, t_un;
    logic [7:0] t_rdd;
    logic [4:0] t_lvl;
    int         t_m = 0;
    logic [7:0] t_q[$];
    logic [7:0] t_last = 8'h00;

    sync_fifo #(.BITS(8), .SIZE(16), .FWFT(0), .AF_THRESH(12), .AE_THRESH(3)) u_t (
        .clk(clk), .rst(t_rst), .wr_en(t_wr), .wr_data(t_wd), .wr_full(t_full),
        .wr_almost_full(t_af), .rd_en(t_rd), .rd_data(t_rdd), .rd_empty(t_empty),
        .rd_almost_empty(t_ae), .level(t_lvl), .overflow(t_ov), .underflow(t_un)
    );

    // Instance F: BITS=8, SIZE=5, first-word-fall-through
    logic       f_rst = 1'b1, f_wr = 1'b0, f_rd = 1'b0;
    logic [7:0] f_wd = 8'h00;
    logic       f_full, f_af, f_empty, f_ae, f_ov, f_un;
    logic [7:0] f_rdd;
    logic [2:0] f_lvl;

    sync_fifo #(.BITS(8), .SIZE(5), .FWFT(1)) u_f (
        .clk(clk), .rst(f_rst), .wr_en(f_wr), .wr_data(f_wd), .wr_full(f_full),
        .wr_almost_full(f_af), .rd_en(f_rd), .rd_data(f_rdd), .rd_empty(f_empty),
        .rd_almost_empty(f_ae), .level(f_lvl), .overflow(f_ov), .underflow(f_un)
    );

    task automatic a_chk(input bit eov, input bit eun);
        chk("a_level",    32'(a_lvl),   32'(a_m));
        chk("a_full",     32'(a_full),  32'(a_m == 5));
        chk("a_afull",    32'(a_af),    32'(a_m >= 3));
        chk("a_empty",    32'(a_empty), 32'(a_m == 0));
        chk("a_aempty",   32'(a_ae),    32'(a_m <= 1));
        chk("a_overflow", 32'(a_ov),    32'(eov));
        chk("a_underflw", 32'(a_un),    32'(eun));
        chk("a_rd_data",  32'(a_rdd),   32'(a_last));
    endtask

    task automatic a_step(input logic w, input logic [7:0] d, input logic r);
        bit wacc, racc;
        wacc = w && (a_m < 5);
        racc = r && (a_m > 0);
        a_wr = w; a_wd = d; a_rd = r;
        if (racc) a_last = a_q.pop_front();
        if (wacc) a_q.push_back(d);
        a_m = a_m + int'(wacc) - int'(racc);
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
        a_chk(w && !wacc, r && !racc);
    endtask

    task automatic a_reset();
        a_rst = 1'b1; a_wr = 1'b1; a_wd = 8'hEE; a_rd = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
        a_m = 0; a_q.delete(); a_last = 8'h00;
        a_chk(1'b0, 1'b0);
    endtask

    task automatic t_chk(input bit eov, input bit eun);
        chk("t_level",    32'(t_lvl),   32'(t_m));
        chk("t_full",     32'(t_full),  32'(t_m == 16));
        chk("t_afull",    32'(t_af),    32'(t_m >= 12));
        chk("t_empty",    32'(t_empty), 32'(t_m == 0));
        chk("t_aempty",   32'(t_ae),    32'(t_m <= 3));
        chk("t_overflow", 32'(t_ov),    32'(eov));
        chk("t_underflw", 32'(t_un),    32'(eun));
        chk("t_rd_data",  32'(t_rdd),   32'(t_last));
    endtask

    task automatic t_step(input logic w, input logic [7:0] d, input logic r);
        bit wacc, racc;
        wacc = w && (t_m < 16);
        racc = r && (t_m > 0);
        t_wr = w; t_wd = d; t_rd = r;
        if (racc) t_last = t_q.pop_front();
        if (wacc) t_q.push_back(d);
        t_m = t_m + int'(wacc) - int'(racc);
        @(posedge clk); #1;
        t_wr = 1'b0; t_rd = 1'b0;
        t_chk(w && !wacc, r && !racc);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        a_rst = 1'b0; t_rst = 1'b0; f_rst = 1'b0;
        a_chk(1'b0, 1'b0);
        t_chk(1'b0, 1'b0);
        chk("f_empty_rst", 32'(f_empty), 32'd1);
        chk("f_level_rst", 32'(f_lvl),   32'd0);

        a_step(1'b0, 8'h00, 1'b0);
        a_step(1'b0, 8'h00, 1'b0);

        // Fill past full: sixth write must be dropped with one overflow pulse.
        for (int i = 0; i < 6; i++) a_step(1'b1, 8'(8'h11 + i), 1'b0);
        a_step(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) a_step(1'b0, 8'h00, 1'b1);
        a_step(1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 13; i++) begin
            a_step(1'b1, 8'(8'h30 + i), 1'b0);
            a_step(1'b0, 8'h00, 1'b1);
        end

        for (int i = 0; i < 3; i++) a_step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 10; i++) a_step(1'b1, 8'(8'h50 + i), 1'b1);
        for (int i = 0; i < 3; i++) a_step(1'b0, 8'h00, 1'b1);
        a_step(1'b1, 8'h77, 1'b1);
        a_step(1'b0, 8'h00, 1'b1);

        // Standard-mode latency: data only after an accepted read.
        a_step(1'b1, 8'hA5, 1'b0);
        a_step(1'b0, 8'h00, 1'b0);
        a_step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 3; i++) a_step(1'b1, 8'(8'h60 + i), 1'b0);
        a_reset();
        a_step(1'b0, 8'h00, 1'b1);
        a_step(1'b1, 8'h99, 1'b0);
        a_step(1'b0, 8'h00, 1'b1);

        for (int i = 0; i < 17; i++) t_step(1'b1, 8'(8'h80 + i), 1'b0);
        for (int i = 0; i < 17; i++) t_step(1'b0, 8'h00, 1'b1);

        // FWFT: head visible one cycle after the write, pop exposes the next entry.
        f_wr = 1'b1; f_wd = 8'hA5;
        @(posedge clk); #1;
        f_wr = 1'b0;
        chk("f_data_a5",   32'(f_rdd),   32'h0000_00A5);
        chk("f_empty_a5",  32'(f_empty), 32'd0);
        chk("f_level_a5",  32'(f_lvl),   32'd1);
        f_wr = 1'b1; f_wd = 8'h5A; f_rd = 1'b1;
        @(posedge clk); #1;
        f_wr = 1'b0; f_rd = 1'b0;
        chk("f_data_5a",   32'(f_rdd),   32'h0000_005A);
        chk("f_level_5a",  32'(f_lvl),   32'd1);
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        chk("f_empty_end", 32'(f_empty), 32'd1);
        chk("f_level_end", 32'(f_lvl),   32'd0);
        chk("f_unf_end",   32'(f_un),    32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
